// File: rtl/pixel_packer.sv
// pixel_packer
// Packs a stream of PIX_W-bit pixels into WORD_W-bit words and writes them to
// consecutive frame buffer addresses 0..DEPTH-1. Supports LSB- or MSB-first
// slot order, explicit frame start/end with flush of a partial last word,
// full-rate input with no dead cycles, and frame status pulses.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   frame_start in   pulse: discard current frame, restart at address 0
//   frame_end   in   pulse: close frame early, flushing any partial word
//   pix_de      in   pixel valid
//   pix_data    in   [PIX_W-1:0] pixel value
//   we          out  RAM write enable, one pulse per word
//   wData       out  [WORD_W-1:0] packed word (held while we=0)
//   wAddr       out  [ADDR_W-1:0] word address (held while we=0)
//   frame_tick  out  pulse: frame closed
//   frame_short out  qualifies frame_tick: closed before DEPTH words
//   abort       out  pulse: a non-empty frame was discarded by frame_start
module pixel_packer #(
  parameter int PIX_W     = 1,
  parameter int WORD_W    = 8,
  parameter int DEPTH     = 5100,
  parameter int MSB_FIRST = 0,
  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_de,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              we,
  output logic [WORD_W-1:0] wData,
  output logic [ADDR_W-1:0] wAddr,
  output logic              frame_tick,
  output logic              frame_short,
  output logic              abort
);

  localparam int PPW   = WORD_W / PIX_W;
  localparam int CNT_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PPW - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  generate
    if ((PIX_W < 1) || (WORD_W % PIX_W != 0)) begin : g_bad_width
      $error("pixel_packer: WORD_W must be a positive integer multiple of PIX_W");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t              state_r, state_next_s, base_state_s;
  logic [CNT_W-1:0]    pix_cnt_r, cnt_next_s, base_cnt_s, slot_s;
  logic [ADDR_W-1:0]   word_idx_r, idx_next_s, base_idx_s;
  logic [WORD_W-1:0]   acc_r, acc_next_s, base_acc_s, fill_acc_s, pix_acc_s;
  logic                frame_open_s, word_done_s, last_word_s, end_now_s, flush_s;
  logic                we_next_s, tick_next_s, short_next_s, abort_next_s;

  logic                we_r, tick_r, short_r, abort_r;
  logic [WORD_W-1:0]   wdata_r;
  logic [ADDR_W-1:0]   waddr_r;

  // Next-state and output decode; frame_start first rewinds the view of the
  // current state so a same-cycle pixel lands as pixel 0 of the new frame.
  always_comb begin
    base_state_s = state_r;
    base_cnt_s   = pix_cnt_r;
    base_idx_s   = word_idx_r;
    base_acc_s   = acc_r;
    if (frame_start) begin
      base_state_s = ST_IDLE;
      base_cnt_s   = {CNT_W{1'b0}};
      base_idx_s   = {ADDR_W{1'b0}};
      base_acc_s   = {WORD_W{1'b0}};
    end else begin
      base_state_s = state_r;
    end

    if (MSB_FIRST != 0) begin
      slot_s = LAST_CNT - base_cnt_s;
    end else begin
      slot_s = base_cnt_s;
    end

    fill_acc_s = base_acc_s;
    fill_acc_s[int'(slot_s) * PIX_W +: PIX_W] = pix_data;

    if (pix_de) begin
      pix_acc_s = fill_acc_s;
    end else begin
      pix_acc_s = base_acc_s;
    end

    // A frame is open once any pixel has been accepted, including this cycle's.
    case (base_state_s)
      ST_IDLE: frame_open_s = pix_de;
      ST_FILL: frame_open_s = 1'b1;
      default: frame_open_s = 1'b0;
    endcase

    word_done_s = pix_de && (base_cnt_s == LAST_CNT);
    last_word_s = word_done_s && (base_idx_s == LAST_IDX);
    // A frame_end coinciding with the natural close is absorbed by it (not short).
    end_now_s   = frame_end && !frame_start && frame_open_s && !last_word_s;
    flush_s     = end_now_s && !word_done_s && (pix_de || (base_cnt_s != {CNT_W{1'b0}}));

    we_next_s    = word_done_s || flush_s;
    tick_next_s  = last_word_s || end_now_s;
    short_next_s = end_now_s;
    abort_next_s = frame_start && (state_r == ST_FILL);

    state_next_s = base_state_s;
    cnt_next_s   = base_cnt_s;
    idx_next_s   = base_idx_s;
    acc_next_s   = base_acc_s;
    if (last_word_s || end_now_s) begin
      state_next_s = ST_IDLE;
      cnt_next_s   = {CNT_W{1'b0}};
      idx_next_s   = {ADDR_W{1'b0}};
      acc_next_s   = {WORD_W{1'b0}};
    end else if (word_done_s) begin
      state_next_s = ST_FILL;
      cnt_next_s   = {CNT_W{1'b0}};
      idx_next_s   = base_idx_s + ADDR_W'(1);
      acc_next_s   = {WORD_W{1'b0}};
    end else if (pix_de) begin
      state_next_s = ST_FILL;
      cnt_next_s   = base_cnt_s + CNT_W'(1);
      acc_next_s   = fill_acc_s;
    end else begin
      state_next_s = base_state_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath state: pixel counter, word index and accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt_r  <= {CNT_W{1'b0}};
      word_idx_r <= {ADDR_W{1'b0}};
      acc_r      <= {WORD_W{1'b0}};
    end else begin
      pix_cnt_r  <= cnt_next_s;
      word_idx_r <= idx_next_s;
      acc_r      <= acc_next_s;
    end
  end

  // Registered outputs; data/address only change on a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r    <= 1'b0;
      wdata_r <= {WORD_W{1'b0}};
      waddr_r <= {ADDR_W{1'b0}};
      tick_r  <= 1'b0;
      short_r <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      we_r    <= we_next_s;
      tick_r  <= tick_next_s;
      short_r <= short_next_s;
      abort_r <= abort_next_s;
      if (we_next_s) begin
        wdata_r <= pix_acc_s;
        waddr_r <= base_idx_s;
      end else begin
        wdata_r <= wdata_r;
        waddr_r <= waddr_r;
      end
    end
  end

  assign we          = we_r;
  assign wData       = wdata_r;
  assign wAddr       = waddr_r;
  assign frame_tick  = tick_r;
  assign frame_short = short_r;
  assign abort       = abort_r;

endmodule

// File: tb/tb_pixel_packer.sv
module tb_pixel_packer;

  logic clk = 1'b0;
  logic reset;
  logic frame_start, frame_end, pix_de, pix_d;
  logic [1:0] pix_dc;

  logic       a_we, a_tick, a_short, a_abort;
  logic [7:0] a_data;
  logic [1:0] a_addr;
  logic       b_we, b_tick, b_short, b_abort;
  logic [7:0] b_data;
  logic [1:0] b_addr;
  logic       c_we, c_tick, c_short, c_abort;
  logic [7:0] c_data;
  logic [1:0] c_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pixel_packer #(.PIX_W(1), .WORD_W(8), .DEPTH(4), .MSB_FIRST(0)) dut_a (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pix_de(pix_de), .pix_data(pix_d), .we(a_we), .wData(a_data), .wAddr(a_addr),
    .frame_tick(a_tick), .frame_short(a_short), .abort(a_abort));

  pixel_packer #(.PIX_W(1), .WORD_W(8), .DEPTH(4), .MSB_FIRST(1)) dut_b (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pix_de(pix_de), .pix_data(pix_d), .we(b_we), .wData(b_data), .wAddr(b_addr),
    .frame_tick(b_tick), .frame_short(b_short), .abort(b_abort));

  pixel_packer #(.PIX_W(2), .WORD_W(8), .DEPTH(4), .MSB_FIRST(0)) dut_c (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .pix_de(pix_de), .pix_data(pix_dc), .we(c_we), .wData(c_data), .wAddr(c_addr),
    .frame_tick(c_tick), .frame_short(c_short), .abort(c_abort));

  // Output tuple layout: {we, wData, wAddr, frame_tick, frame_short, abort}
  typedef struct {
    logic       s, e, de, d;
    logic       we;
    logic [7:0] da, db;
    logic [1:0] ad;
    logic       tk, sh, ab;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {we,data,addr,tick,short,abort}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ab(input string name, input logic we, input logic [7:0] da, input logic [7:0] db,
                        input logic [1:0] ad, input logic tk, input logic sh, input logic ab);
    chk({name, " lsb"}, {a_we, a_data, a_addr, a_tick, a_short, a_abort}, {we, da, ad, tk, sh, ab});
    chk({name, " msb"}, {b_we, b_data, b_addr, b_tick, b_short, b_abort}, {we, db, ad, tk, sh, ab});
  endtask

  task automatic step(input logic s, input logic e, input logic de, input logic d, input logic [1:0] dc);
    frame_start = s;
    frame_end   = e;
    pix_de      = de;
    pix_d       = d;
    pix_dc      = dc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hda, hdb, hdc;
    logic [1:0] had, hac;
    logic [7:0] words [5];
    logic [7:0] wordsb [5];
    logic [7:0] p5a;
    logic [1:0] cd [8];

    words  = '{8'hA5, 8'h3C, 8'h0F, 8'hC3, 8'h81};
    wordsb = '{8'hA5, 8'h3C, 8'hF0, 8'hC3, 8'h81};
    p5a    = 8'h5A;
    cd     = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3};

    //             s     e     de    d     we    da     db     ad    tk    sh    ab
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h8D, 8'hB1, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h8D, 8'hB1, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h8D, 8'hB1, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h8D, 8'hB1, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h8D, 8'hB1, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h8D, 8'hB1, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h8D, 8'hB1, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 8'hE0, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07, 8'hE0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07, 8'hE0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h07, 8'hE0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07, 8'hE0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 8'hE0, 2'd0, 1'b0, 1'b0, 1'b0};

    // Reset state
    reset = 1'b1;
    frame_start = 1'b0; frame_end = 1'b0; pix_de = 1'b0; pix_d = 1'b0; pix_dc = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_ab("reset", 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("reset pix2", {c_we, c_data, c_addr, c_tick, c_short, c_abort}, 14'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table: basic packing, early end, idle end, same-cycle end, start/abort rules
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].s, tbl[i].e, tbl[i].de, tbl[i].d, 2'd0);
      chk_ab($sformatf("vec%0d", i), tbl[i].we, tbl[i].da, tbl[i].db, tbl[i].ad,
             tbl[i].tk, tbl[i].sh, tbl[i].ab);
    end

    // Continuous 40 pixels: full frame of 4 words, then first word of next frame
    hda = 8'h07; hdb = 8'hE0; had = 2'd0;
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 8; k++) begin
        step(1'b0, 1'b0, 1'b1, words[w][k], 2'd0);
        if (k == 7) begin
          hda = words[w]; hdb = wordsb[w]; had = 2'(w);
        end
        chk_ab($sformatf("cont w%0d k%0d", w, k), (k == 7), hda, hdb, had,
               (k == 7) && (w == 3), 1'b0, 1'b0);
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk_ab("restart abort", 1'b0, hda, hdb, had, 1'b0, 1'b0, 1'b1);

    // 11 ones then frame_end: FF@0, flush 07@1 short
    for (int k = 0; k < 11; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
      if (k == 7) begin
        hda = 8'hFF; hdb = 8'hFF; had = 2'd0;
      end
      chk_ab($sformatf("ones k%0d", k), (k == 7), hda, hdb, had, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    hda = 8'h07; hdb = 8'hE0; had = 2'd1;
    chk_ab("flush", 1'b1, hda, hdb, had, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    chk_ab("end idle", 1'b0, hda, hdb, had, 1'b0, 1'b0, 1'b0);

    // 5 pixels, frame_start with a pixel, then 7 zeros
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
      chk_ab($sformatf("pre-abort k%0d", k), 1'b0, hda, hdb, had, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
    chk_ab("abort", 1'b0, hda, hdb, had, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      if (k == 6) begin
        hda = 8'h01; hdb = 8'h80; had = 2'd0;
      end
      chk_ab($sformatf("post-abort k%0d", k), (k == 6), hda, hdb, had, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-word
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
      chk_ab($sformatf("pre-reset k%0d", k), 1'b0, hda, hdb, had, 1'b0, 1'b0, 1'b0);
    end
    #3;
    reset = 1'b1;
    #1;
    chk_ab("async reset", 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("async reset pix2", {c_we, c_data, c_addr, c_tick, c_short, c_abort}, 14'd0);
    @(negedge clk);
    reset = 1'b0;

    // After release: 8 pixels to address 0; 2-bit packer gets 3,0,1,2 / 2,1,0,3
    hda = 8'h00; hdb = 8'h00; had = 2'd0;
    hdc = 8'h00; hac = 2'd0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b1, p5a[k], cd[k]);
      if (k == 7) begin
        hda = 8'h5A; hdb = 8'h5A; had = 2'd0;
      end
      if (k == 3) begin
        hdc = 8'h93; hac = 2'd0;
      end
      if (k == 7) begin
        hdc = 8'hC6; hac = 2'd1;
      end
      chk_ab($sformatf("post-reset k%0d", k), (k == 7), hda, hdb, had, 1'b0, 1'b0, 1'b0);
      chk($sformatf("pix2 k%0d", k), {c_we, c_data, c_addr, c_tick, c_short, c_abort},
          {(k == 3) || (k == 7), hdc, hac, 1'b0, 1'b0, 1'b0});
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk_ab("final idle", 1'b0, hda, hdb, had, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_packer.md
# pixel_packer

Parametrised pixel packer between the edge-detection stream and the frame buffer RAM. It accepts one PIX_W-bit pixel per `pix_de` cycle and packs PIX_PER_WORD = WORD_W/PIX_W pixels into each WORD_W-bit word. Completed words are written to consecutive addresses 0..DEPTH-1. It generalises the 1-bit/8-bit packer with these additions:
- selectable bit order
- explicit frame start and frame end, with flush of a partial last word
- full-rate input with no dead cycles
- a frame status output

## Interface
- PIX_W, 1, bits per pixel; WORD_W must be an integer multiple of PIX_W (elaboration error otherwise).
- WORD_W, 8, RAM data width.
- DEPTH, 5100, words per full frame; ADDR_W = $clog2(DEPTH).
- MSB_FIRST, 0, 0: pixel k lands in wData[k*PIX_W +: PIX_W]; 1: pixel k lands in wData[(PIX_PER_WORD-1-k)*PIX_W +: PIX_W].
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse: discard the current frame and restart at address 0.
- frame_end  in  1  one-cycle pulse: close the frame early, flushing any partial word.
- pix_de  in  1  pixel valid.
- pix_data  in  PIX_W  pixel value.
- we  out  1  RAM write enable, one-cycle pulse per word.
- wData  out  WORD_W  packed word; valid when `we`=1.
- wAddr  out  ADDR_W  word address; valid when `we`=1.
- frame_tick  out  1  one-cycle pulse: frame closed.
- frame_short  out  1  qualifies `frame_tick`; 1 = frame closed by `frame_end` before DEPTH words.
- abort  out  1  one-cycle pulse: a non-empty frame was discarded by `frame_start`.

## Operation
- Internal state:
  - pix_cnt, range 0..PIX_PER_WORD-1
  - word_idx, range 0..DEPTH-1
  - word accumulator, which is zero-filled after every write or discard
  - FSM with two states: ST_IDLE (no pixel accepted in the current frame) and ST_FILL (at least one pixel accepted).
- Pixel accept (`pix_de`=1): write the pixel into the accumulator slot for pix_cnt (order per MSB_FIRST), then pix_cnt++.
  - ST_IDLE goes to ST_FILL.
  - When pix_cnt = PIX_PER_WORD-1: the word is complete. Write it at word_idx, clear pix_cnt and the accumulator, then word_idx++.
- Natural frame end: completing the word at word_idx = DEPTH-1 writes it, asserts `frame_tick` with `frame_short`=0, wraps word_idx to 0 and returns to ST_IDLE. The next frame is accepted immediately.
- `frame_end` in ST_FILL:
  - Partial word pending (pix_cnt≠0): write it at word_idx with unfilled slots zero, and assert `frame_tick` + `frame_short` in the same cycle as that `we`.
  - No partial word pending: assert `frame_tick` + `frame_short` with no write.
  - In both cases word_idx and pix_cnt clear and the FSM goes to ST_IDLE.
  - If `frame_end` closes exactly at DEPTH words, `frame_short`=0.
- `frame_end` in ST_IDLE: ignored, with no tick.
- `pix_de` and `frame_end` in the same cycle: the pixel is accepted first, then the end is processed. If that pixel completes a word, one write occurs, carrying the tick.
- `frame_start`:
  - Clears pix_cnt, word_idx and the accumulator and sets the FSM to ST_IDLE.
  - If the FSM was in ST_FILL, or a word was written in the frame, it pulses `abort`. No flush and no tick are produced.
  - `pix_de` in the same cycle becomes pixel 0 of the new frame.
  - `frame_start` has priority over `frame_end`; a `frame_end` in the same cycle is ignored.
- Addresses never exceed DEPTH-1. There is no overflow condition because word_idx wraps at frame close.

## Timing
- All outputs are registered. Reset value of every output is 0: `we`, `wData`, `wAddr`, `frame_tick`, `frame_short`, `abort`.
- Latency: `we`/`wData`/`wAddr` assert the cycle after the `pix_de` edge carrying the last pixel of a word, or after the `frame_end` cycle for a flush.
- `frame_tick`/`frame_short` are coincident with the final `we`. Without a flush write, they are one cycle after `frame_end`.
- `abort` is one cycle after `frame_start`.
- Throughput: one pixel per cycle, sustained indefinitely, with no stall and no bubble at word or frame boundaries.
- `wData`/`wAddr` hold their last values when `we`=0.
- Asynchronous `reset` mid-frame discards all partial data. The first `pix_de` after release is pixel 0, address 0.

## Test plan
- PIX_W=1, WORD_W=8, MSB_FIRST=0; pixels 1,0,1,1,0,0,0,1 on 8 consecutive cycles -> one `we`, `wData`=8'h8D, `wAddr`=0, on the cycle after the 8th pixel.
- Same stream with MSB_FIRST=1 -> `wData`=8'hB1. Then PIX_W=2, WORD_W=8, pixels 3,0,1,2 -> `wData`=8'h93 (LSB-first).
- DEPTH=4, 32 continuous pixels -> `wAddr` 0,1,2,3 with no gaps. `frame_tick`=1 and `frame_short`=0 with addr-3 `we`. Pixel 33 goes to addr 0.
- DEPTH=4; 11 pixels of 1, then `frame_end` -> writes 8'hFF@0, then 8'h07@1 with `frame_tick` and `frame_short`=1. A subsequent `frame_end` alone -> no output.
- 5 pixels, then `frame_start` with `pix_de`=1, data 1 -> `abort` pulse and no write. The next 7 pixels of 0 -> `wData`=8'h01@0.
- Assert `reset` asynchronously mid-word (between edges) -> all outputs are 0 immediately. After release, the next 8 pixels are written at address 0.
